// File: rtl/fruitninja_rom_arbiter_if.sv
// Bundles the VGA scan, pixel-query and ROM signals of the background ROM arbiter.
// The slave modport is the arbiter's view; the master modport drives it (VGA, game logic, ROM).
interface fruitninja_rom_arbiter_if;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic        q_req;
   logic [9:0]  q_x;
   logic [9:0]  q_y;
   logic        q_ack;
   logic [7:0]  q_index;
   logic        q_oob;
   logic        q_busy;
   logic [18:0] rom_address;
   logic [7:0]  rom_q;
   logic [7:0]  pix_index;

   modport slave (
      input  DrawX, DrawY, blank, q_req, q_x, q_y, rom_q,
      output q_ack, q_index, q_oob, q_busy, rom_address, pix_index
   );

   modport master (
      output DrawX, DrawY, blank, q_req, q_x, q_y, rom_q,
      input  q_ack, q_index, q_oob, q_busy, rom_address, pix_index
   );
endinterface

// File: rtl/fruitninja_rom_arbiter.sv
// Shares the 640x480 background ROM between scan-out (2-cycle fixed latency, never stalled)
// and a pixel query port served only in blanking (ack 3 edges after accept, +1 per blanked ISSUE cycle).
module fruitninja_rom_arbiter (
   input  logic                     vga_clk_i,
   input  logic                     reset_i,
   fruitninja_rom_arbiter_if.slave  rom_if
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [18:0] q_addr_q, q_addr_d;
   logic        q_ack_q, q_ack_d;
   logic [7:0]  q_index_q, q_index_d;
   logic        q_oob_q, q_oob_d;
   logic        d_vis_q;
   logic [7:0]  pix_index_q;

   // x + y*640 without a multiplier: y*640 = (y<<9) + (y<<7)
   function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
      return {9'd0, x} + {y, 9'd0} + {2'd0, y, 7'd0};
   endfunction

   logic [18:0] disp_addr;
   logic [18:0] req_addr;
   logic        req_in_bounds;

   assign disp_addr     = pix_addr(rom_if.DrawX, rom_if.DrawY);
   assign req_addr      = pix_addr(rom_if.q_x, rom_if.q_y);
   assign req_in_bounds = (rom_if.q_x < 10'd640) && (rom_if.q_y < 10'd480);

   always_comb begin
      rom_if.rom_address = 19'd0;
      if (rom_if.blank) begin
         rom_if.rom_address = disp_addr;
      end else if (state_q == ISSUE) begin
         rom_if.rom_address = q_addr_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      q_addr_d  = q_addr_q;
      q_ack_d   = q_ack_q;
      q_index_d = q_index_q;
      q_oob_d   = q_oob_q;
      unique case (state_q)
         IDLE: begin
            if (rom_if.q_req) begin
               if (req_in_bounds) begin
                  q_addr_d = req_addr;
                  state_d  = ISSUE;
               end else begin
                  q_index_d = 8'h00;
                  q_oob_d   = 1'b1;
                  q_ack_d   = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         ISSUE: begin
            // Active video owns the ROM; retry until a blanking cycle.
            if (!rom_if.blank) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            q_index_d = rom_if.rom_q;
            q_oob_d   = 1'b0;
            q_ack_d   = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            q_ack_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge vga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         q_addr_q    <= 19'd0;
         q_ack_q     <= 1'b0;
         q_index_q   <= 8'h00;
         q_oob_q     <= 1'b0;
         d_vis_q     <= 1'b0;
         pix_index_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         q_addr_q    <= q_addr_d;
         q_ack_q     <= q_ack_d;
         q_index_q   <= q_index_d;
         q_oob_q     <= q_oob_d;
         d_vis_q     <= rom_if.blank;
         pix_index_q <= d_vis_q ? rom_if.rom_q : 8'h00;
      end
   end

   assign rom_if.q_ack     = q_ack_q;
   assign rom_if.q_index   = q_index_q;
   assign rom_if.q_oob     = q_oob_q;
   assign rom_if.q_busy    = (state_q != IDLE);
   assign rom_if.pix_index = pix_index_q;

endmodule

// File: tb/tb_fruitninja_rom_arbiter.sv
// Directed bench for fruitninja_rom_arbiter with a 1-cycle-latency ROM model.
// Inputs are driven and outputs sampled 2 ns after each rising edge.
module tb_fruitninja_rom_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   fruitninja_rom_arbiter_if bus ();

   fruitninja_rom_arbiter dut (
      .vga_clk_i (clk),
      .reset_i   (rst),
      .rom_if    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word 1290 is pinned to 8'h5A; everything else folds the address bytes together.
   function automatic logic [7:0] rom_word(input logic [18:0] a);
      if (a == 19'd1290) return 8'h5A;
      return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
   endfunction

   always @(posedge clk) bus.rom_q <= rom_word(bus.rom_address);

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_query(input logic req, input logic [9:0] x, input logic [9:0] y);
      bus.q_req = req;
      bus.q_x   = x;
      bus.q_y   = y;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.blank = 1'b0;
      bus.DrawX = 10'd0;
      bus.DrawY = 10'd0;
      bus.rom_q = 8'h00;
      set_query(1'b0, 10'd0, 10'd0);
      repeat (3) tick();

      // Reset values, and the mux still routes the display address during reset.
      chk_eq("rst_ack",   bus.q_ack, 0);
      chk_eq("rst_index", bus.q_index, 0);
      chk_eq("rst_oob",   bus.q_oob, 0);
      chk_eq("rst_pix",   bus.pix_index, 0);
      chk_eq("rst_busy",  bus.q_busy, 0);
      chk_eq("rst_addr_blank0", bus.rom_address, 0);
      bus.blank = 1'b1; bus.DrawX = 10'd5; bus.DrawY = 10'd1;
      #1;
      chk_eq("rst_addr_blank1", bus.rom_address, 645);
      bus.blank = 1'b0; bus.DrawX = 10'd0; bus.DrawY = 10'd0;
      tick();
      rst = 1'b0;
      tick();

      // In-bounds query (10,2) in blanking.
      set_query(1'b1, 10'd10, 10'd2);
      tick();
      chk_eq("q1_busy_issue", bus.q_busy, 1);
      chk_eq("q1_addr_issue", bus.rom_address, 1290);
      tick();
      chk_eq("q1_ack_capture", bus.q_ack, 0);
      tick();
      chk_eq("q1_ack",   bus.q_ack, 1);
      chk_eq("q1_index", bus.q_index, 8'h5A);
      chk_eq("q1_oob",   bus.q_oob, 0);
      set_query(1'b0, 10'd0, 10'd0);
      tick();
      chk_eq("q1_ack_drop",   bus.q_ack, 0);
      chk_eq("q1_busy_idle",  bus.q_busy, 0);
      chk_eq("q1_index_hold", bus.q_index, 8'h5A);

      // Query (100,100) while active video holds the ROM for 20 cycles.
      bus.blank = 1'b1; bus.DrawY = 10'd7;
      set_query(1'b1, 10'd100, 10'd100);
      tick();
      for (int i = 0; i < 20; i++) begin
         bus.DrawX = 10'(i);
         #1;
         chk_eq($sformatf("q2_disp_addr_%0d", i), bus.rom_address, 4480 + i);
         chk_eq($sformatf("q2_busy_%0d", i), bus.q_busy, 1);
         chk_eq($sformatf("q2_noack_%0d", i), bus.q_ack, 0);
         tick();
      end
      bus.blank = 1'b0;
      #1;
      chk_eq("q2_addr_issue", bus.rom_address, 64100);
      tick();
      chk_eq("q2_ack_capture", bus.q_ack, 0);
      tick();
      chk_eq("q2_ack",   bus.q_ack, 1);
      chk_eq("q2_index", bus.q_index, 8'h9E);
      set_query(1'b0, 10'd0, 10'd0);
      tick();
      chk_eq("q2_ack_drop", bus.q_ack, 0);

      // Out-of-bounds queries never touch the ROM.
      set_query(1'b1, 10'd640, 10'd0);
      #1;
      chk_eq("oob_x_addr_idle", bus.rom_address, 0);
      tick();
      chk_eq("oob_x_ack",   bus.q_ack, 1);
      chk_eq("oob_x_oob",   bus.q_oob, 1);
      chk_eq("oob_x_index", bus.q_index, 0);
      chk_eq("oob_x_addr",  bus.rom_address, 0);
      set_query(1'b0, 10'd0, 10'd0);
      tick();
      chk_eq("oob_x_ack_drop", bus.q_ack, 0);
      chk_eq("oob_x_busy",     bus.q_busy, 0);
      set_query(1'b1, 10'd0, 10'd480);
      tick();
      chk_eq("oob_y_ack",  bus.q_ack, 1);
      chk_eq("oob_y_oob",  bus.q_oob, 1);
      chk_eq("oob_y_addr", bus.rom_address, 0);
      set_query(1'b0, 10'd0, 10'd0);
      tick();
      chk_eq("oob_y_ack_drop", bus.q_ack, 0);
      chk_eq("oob_y_oob_hold", bus.q_oob, 1);

      // Display at the last pixel, then blanking zeroes the colour index.
      bus.blank = 1'b1; bus.DrawX = 10'd639; bus.DrawY = 10'd479;
      #1;
      chk_eq("disp_last_addr", bus.rom_address, 307199);
      tick();
      tick();
      chk_eq("disp_last_pix", bus.pix_index, 8'h54);
      bus.blank = 1'b0;
      tick();
      chk_eq("disp_blank_pix_lag", bus.pix_index, 8'h54);
      tick();
      chk_eq("disp_blank_pix", bus.pix_index, 0);

      // Back-to-back queries: the next request is presented on the ack edge.
      set_query(1'b1, 10'd1, 10'd0);
      tick();
      tick();
      tick();
      chk_eq("b2b_ack1",   bus.q_ack, 1);
      chk_eq("b2b_index1", bus.q_index, 8'h01);
      set_query(1'b1, 10'd2, 10'd1);
      tick();
      chk_eq("b2b_done_no_retrigger", bus.q_busy, 0);
      chk_eq("b2b_ack1_drop", bus.q_ack, 0);
      tick();
      chk_eq("b2b_accept2_busy", bus.q_busy, 1);
      chk_eq("b2b_accept2_addr", bus.rom_address, 642);
      tick();
      tick();
      chk_eq("b2b_ack2",   bus.q_ack, 1);
      chk_eq("b2b_index2", bus.q_index, 8'h80);
      set_query(1'b0, 10'd0, 10'd0);
      tick();
      chk_eq("b2b_ack2_drop", bus.q_ack, 0);

      // Reset asserted while in CAPTURE aborts the query without an ack.
      set_query(1'b1, 10'd10, 10'd2);
      tick();
      tick();
      chk_eq("rstq_busy_capture", bus.q_busy, 1);
      rst = 1'b1;
      #1;
      chk_eq("rstq_busy",  bus.q_busy, 0);
      chk_eq("rstq_ack",   bus.q_ack, 0);
      chk_eq("rstq_index", bus.q_index, 0);
      chk_eq("rstq_oob",   bus.q_oob, 0);
      chk_eq("rstq_pix",   bus.pix_index, 0);
      tick();
      set_query(1'b0, 10'd0, 10'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_eq($sformatf("rstq_noack_%0d", i), bus.q_ack, 0);
      end
      set_query(1'b1, 10'd10, 10'd2);
      tick();
      tick();
      tick();
      chk_eq("rstq_requery_ack",   bus.q_ack, 1);
      chk_eq("rstq_requery_index", bus.q_index, 8'h5A);
      set_query(1'b0, 10'd0, 10'd0);
      tick();
      chk_eq("rstq_requery_idle", bus.q_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
